// File: rtl/ibuffer_issue_pkg.sv
// Shared sizing and helper functions for the per-warp instruction buffer
// and anything that needs to decode warp grants (e.g. scheduler logging).
package ibuffer_issue_pkg;

    localparam int NUM_WARPS  = 8;
    localparam int WID_W      = 3;
    localparam int INSTR_W    = 32;
    localparam int IBUF_DEPTH = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if (int'(32'd1 << i) < value) begin
                r = i + 1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    function automatic logic [WID_W-1:0] onehot_to_idx(input logic [NUM_WARPS-1:0] onehot);
        logic [WID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (onehot[i]) begin
                idx = idx | WID_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/ibuf_warp_fifo.sv
// Single-warp instruction FIFO; flush clears it and wins over push/pop.
// full is registered so a push is judged against last cycle's occupancy.
module ibuf_warp_fifo
    import ibuffer_issue_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic [clog2(DEPTH):0]  count,
    output logic                   full
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;
    logic [CNT_W-1:0] count_next;

    // Qualify push/pop and compute the next occupancy
    always_comb begin
        push_ok    = push & ~full & ~flush;
        pop_ok     = pop & (count != '0) & ~flush;
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_next = count + CNT_W'(1);
                2'b01:   count_next = count - CNT_W'(1);
                default: count_next = count;
            endcase
        end
    end

    // Pointer, count and full-flag state
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

    // Instruction storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/ibuffer_issue.sv
// Per-warp instruction buffers feeding the warp arbiter: builds the request
// vector, consumes the grant, pops the winner and registers it onto the issue bus.
module ibuffer_issue
    import ibuffer_issue_pkg::*;
#(
    parameter int DEPTH = IBUF_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fetch_valid,
    input  logic [WID_W-1:0]     fetch_warp_id,
    input  logic [INSTR_W-1:0]   fetch_instr,
    output logic [NUM_WARPS-1:0] ibuf_full,
    input  logic [NUM_WARPS-1:0] warp_ready,
    input  logic                 exec_stall,
    input  logic [NUM_WARPS-1:0] flush,
    output logic [NUM_WARPS-1:0] req,
    input  logic [NUM_WARPS-1:0] grt,
    output logic                 issue_valid,
    output logic [WID_W-1:0]     issue_warp_id,
    output logic [INSTR_W-1:0]   issue_instr,
    output logic                 overflow_err
);

    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [NUM_WARPS-1:0] push;
    logic [NUM_WARPS-1:0] not_empty;
    logic [NUM_WARPS-1:0] eff_grt;
    logic [NUM_WARPS-1:0] sel;
    logic [WID_W-1:0]     sel_idx;
    logic                 overflow_hit;
    logic [INSTR_W-1:0]   heads  [NUM_WARPS];
    logic [CNT_W-1:0]     counts [NUM_WARPS];

    genvar w;
    for (w = 0; w < NUM_WARPS; w++) begin : g_warp
        assign push[w]      = fetch_valid & (fetch_warp_id == WID_W'(w));
        assign not_empty[w] = (counts[w] != '0);

        ibuf_warp_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (INSTR_W)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[w]),
            .pop   (sel[w]),
            .flush (flush[w]),
            .din   (fetch_instr),
            .head  (heads[w]),
            .count (counts[w]),
            .full  (ibuf_full[w])
        );
    end

    // Request masking and grant decode; grant bits outside req are ignored and
    // only the lowest surviving bit is honoured should grt ever be non-one-hot
    always_comb begin
        req          = not_empty & warp_ready & ~flush & {NUM_WARPS{~exec_stall}};
        eff_grt      = grt & req;
        sel          = eff_grt & (~eff_grt + NUM_WARPS'(1));
        sel_idx      = onehot_to_idx(sel);
        overflow_hit = fetch_valid & ibuf_full[fetch_warp_id] & ~flush[fetch_warp_id];
    end

    // Issue register and sticky overflow flag
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_valid   <= 1'b0;
            issue_warp_id <= '0;
            issue_instr   <= '0;
            overflow_err  <= 1'b0;
        end else begin
            issue_valid  <= |sel;
            overflow_err <= overflow_err | overflow_hit;
            if (|sel) begin
                issue_warp_id <= sel_idx;
                issue_instr   <= heads[sel_idx];
            end else begin
                issue_warp_id <= issue_warp_id;
                issue_instr   <= issue_instr;
            end
        end
    end

endmodule

// File: tb/tb_ibuffer_issue.sv
// Self-checking bench for ibuffer_issue: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
module tb_ibuffer_issue;
    import ibuffer_issue_pkg::*;

    localparam int NW = NUM_WARPS;
    localparam int D  = IBUF_DEPTH;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 fetch_valid;
    logic [WID_W-1:0]     fetch_warp_id;
    logic [INSTR_W-1:0]   fetch_instr;
    logic [NW-1:0]        ibuf_full;
    logic [NW-1:0]        warp_ready;
    logic                 exec_stall;
    logic [NW-1:0]        flush;
    logic [NW-1:0]        req;
    logic [NW-1:0]        grt;
    logic                 issue_valid;
    logic [WID_W-1:0]     issue_warp_id;
    logic [INSTR_W-1:0]   issue_instr;
    logic                 overflow_err;

    always #5 clk = ~clk;

    ibuffer_issue #(.DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_valid   (fetch_valid),
        .fetch_warp_id (fetch_warp_id),
        .fetch_instr   (fetch_instr),
        .ibuf_full     (ibuf_full),
        .warp_ready    (warp_ready),
        .exec_stall    (exec_stall),
        .flush         (flush),
        .req           (req),
        .grt           (grt),
        .issue_valid   (issue_valid),
        .issue_warp_id (issue_warp_id),
        .issue_instr   (issue_instr),
        .overflow_err  (overflow_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: one queue per warp plus the registered-side state
    logic [INSTR_W-1:0] mq [NW][$];
    logic [NW-1:0]      m_full;
    logic               m_ovf;
    logic               m_valid;
    logic [WID_W-1:0]   m_id;
    logic [INSTR_W-1:0] m_instr;
    logic [NW-1:0]      m_req;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NW-1:0] model_req();
        logic [NW-1:0] r;
        for (int i = 0; i < NW; i++) begin
            r[i] = (mq[i].size() != 0) && warp_ready[i] && !exec_stall && !flush[i];
        end
        return r;
    endfunction

    task automatic model_edge();
        int  g;
        bit  granted;
        if (rst) begin
            for (int i = 0; i < NW; i++) mq[i].delete();
            m_full  = '0;
            m_ovf   = 1'b0;
            m_valid = 1'b0;
            m_id    = '0;
            m_instr = '0;
        end else begin
            granted = 1'b0;
            g = 0;
            for (int i = 0; i < NW; i++) begin
                if (grt[i] && m_req[i] && !granted) begin
                    granted = 1'b1;
                    g = i;
                end
            end
            if (granted) begin
                m_valid = 1'b1;
                m_id    = WID_W'(g);
                m_instr = mq[g].pop_front();
            end else begin
                m_valid = 1'b0;
            end
            if (fetch_valid && !flush[fetch_warp_id]) begin
                if (m_full[fetch_warp_id]) m_ovf = 1'b1;
                else mq[fetch_warp_id].push_back(fetch_instr);
            end
            for (int i = 0; i < NW; i++) begin
                if (flush[i]) mq[i].delete();
                m_full[i] = (mq[i].size() == D);
            end
        end
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge
    task automatic run_cycle();
        m_req = model_req();
        #1;
        check_eq("req", 64'(req), 64'(m_req));
        @(posedge clk);
        model_edge();
        #1;
        check_eq("issue_valid", 64'(issue_valid), 64'(m_valid));
        check_eq("issue_warp_id", 64'(issue_warp_id), 64'(m_id));
        check_eq("issue_instr", 64'(issue_instr), 64'(m_instr));
        check_eq("ibuf_full", 64'(ibuf_full), 64'(m_full));
        check_eq("overflow_err", 64'(overflow_err), 64'(m_ovf));
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0; fetch_valid = 1'b0; fetch_warp_id = '0; fetch_instr = '0;
        warp_ready = '0; exec_stall = 1'b0; flush = '0; grt = '0;
    endtask

    task automatic do_write(input int w, input logic [INSTR_W-1:0] v);
        fetch_valid = 1'b1; fetch_warp_id = WID_W'(w); fetch_instr = v;
        run_cycle();
        fetch_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run_cycle();
        rst = 1'b0;
    endtask

    initial begin
        int start;
        int idx;
        logic [NW-1:0] r;

        idle();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("reset_req", 64'(req), 64'h0);
        check_eq("reset_issue_valid", 64'(issue_valid), 64'h0);
        check_eq("reset_issue_warp_id", 64'(issue_warp_id), 64'h0);
        check_eq("reset_issue_instr", 64'(issue_instr), 64'h0);
        check_eq("reset_ibuf_full", 64'(ibuf_full), 64'h0);
        check_eq("reset_overflow", 64'(overflow_err), 64'h0);
        @(negedge clk);

        // Two words through warp 3
        do_write(3, 32'hA000_0001);
        do_write(3, 32'hA000_0002);
        check_eq("tp1_full3_set", 64'(ibuf_full[3]), 64'h1);
        warp_ready = '1; grt = 8'h08;
        run_cycle();
        check_eq("tp1_first_instr", 64'(issue_instr), 64'hA000_0001);
        check_eq("tp1_first_id", 64'(issue_warp_id), 64'h3);
        check_eq("tp1_full3_clear", 64'(ibuf_full[3]), 64'h0);
        run_cycle();
        check_eq("tp1_second_instr", 64'(issue_instr), 64'hA000_0002);
        check_eq("tp1_second_valid", 64'(issue_valid), 64'h1);
        grt = '0; warp_ready = '0;
        run_cycle();
        check_eq("tp1_idle_valid", 64'(issue_valid), 64'h0);

        // Overflow on warp 5
        do_write(5, 32'h5555_0001);
        do_write(5, 32'h5555_0002);
        do_write(5, 32'h5555_0003);
        check_eq("tp2_overflow", 64'(overflow_err), 64'h1);
        check_eq("tp2_full5", 64'(ibuf_full[5]), 64'h1);
        warp_ready = 8'h20; grt = 8'h20;
        run_cycle();
        run_cycle();
        check_eq("tp2_second_kept", 64'(issue_instr), 64'h5555_0002);
        grt = '0;
        run_cycle();
        check_eq("tp2_third_dropped", 64'(issue_valid), 64'h0);
        do_reset();
        check_eq("tp2_overflow_cleared", 64'(overflow_err), 64'h0);

        // warp_ready gating on warp 2
        do_write(2, 32'h2222_0001);
        warp_ready = 8'h00; grt = 8'h04;
        run_cycle();
        check_eq("tp3_not_ready_no_issue", 64'(issue_valid), 64'h0);
        warp_ready = 8'h04;
        run_cycle();
        check_eq("tp3_issue_id", 64'(issue_warp_id), 64'h2);
        grt = '0;

        // Flush wins over grant and write
        do_write(1, 32'h1111_0001);
        do_write(1, 32'h1111_0002);
        warp_ready = '1; flush = 8'h02; grt = 8'h02;
        fetch_valid = 1'b1; fetch_warp_id = 3'd1; fetch_instr = 32'h1111_0003;
        run_cycle();
        check_eq("tp4_no_issue", 64'(issue_valid), 64'h0);
        check_eq("tp4_no_overflow", 64'(overflow_err), 64'h0);
        check_eq("tp4_not_full", 64'(ibuf_full[1]), 64'h0);
        idle(); warp_ready = '1;
        run_cycle();

        // exec_stall blocks all requests
        warp_ready = '0;
        do_write(0, 32'h0000_00AA);
        do_write(4, 32'h0000_44AA);
        warp_ready = '1; exec_stall = 1'b1; grt = 8'h01;
        run_cycle();
        check_eq("tp5_stall_no_issue", 64'(issue_valid), 64'h0);
        exec_stall = 1'b0; grt = '0;
        run_cycle();

        // Same-cycle push and pop on warp 6, then reset mid-stream
        do_write(6, 32'h6666_0001);
        fetch_valid = 1'b1; fetch_warp_id = 3'd6; fetch_instr = 32'h6666_0002; grt = 8'h40;
        run_cycle();
        check_eq("tp6_old_head", 64'(issue_instr), 64'h6666_0001);
        fetch_valid = 1'b0;
        run_cycle();
        check_eq("tp6_new_head", 64'(issue_instr), 64'h6666_0002);
        grt = 8'h01;
        rst = 1'b1;
        run_cycle();
        check_eq("tp6_rst_valid", 64'(issue_valid), 64'h0);
        check_eq("tp6_rst_instr", 64'(issue_instr), 64'h0);
        idle();
        warp_ready = '1;
        run_cycle();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst        = ($urandom_range(0, 299) == 0);
            exec_stall = ($urandom_range(0, 9) == 0);
            warp_ready = ($urandom_range(0, 3) == 0) ? NW'($urandom) : '1;
            for (int i = 0; i < NW; i++) flush[i] = ($urandom_range(0, 39) == 0);
            fetch_valid   = ($urandom_range(0, 2) != 0);
            fetch_warp_id = WID_W'($urandom_range(0, NW - 1));
            fetch_instr   = $urandom;
            if (m_full[fetch_warp_id] && $urandom_range(0, 19) != 0) fetch_valid = 1'b0;
            r = model_req();
            grt = '0;
            if (r != '0 && $urandom_range(0, 3) != 0) begin
                start = $urandom_range(0, NW - 1);
                for (int t = 0; t < NW; t++) begin
                    idx = (start + t) % NW;
                    if (r[idx] && grt == '0) grt[idx] = 1'b1;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                grt[$urandom_range(0, NW - 1)] = 1'b1;
            end
            run_cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ibuffer_issue.md
Name: ibuffer_issue

Overview:
- Per-warp instruction buffer that sits directly upstream and downstream of the round-robin warp arbiter.
- Holds fetched instructions in small per-warp FIFOs and drives the arbiter's req vector: one bit per warp that has a head instruction, is scoreboard-ready, and is not stalled or flushed.
- Consumes the arbiter's one-hot grt, pops the granted warp's head, and registers it onto the issue bus.

Parameters:
- NUM_WARPS, 8, number of warps; equals the arbiter WIDTH.
- DEPTH, 2, entries per warp FIFO; power of two, at least 2.
- INSTR_W, 32, instruction width in bits.
- WID_W, 3, warp-id width; equals clog2(NUM_WARPS).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fetch_valid  in  1  fetch delivers an instruction this cycle.
- fetch_warp_id  in  WID_W  destination warp.
- fetch_instr  in  INSTR_W  instruction word.
- ibuf_full  out  NUM_WARPS  per-warp full flag, registered; fetch must not write a full warp.
- warp_ready  in  NUM_WARPS  scoreboard: head instruction of warp w has no hazards.
- exec_stall  in  1  issue slot cannot accept this cycle.
- flush  in  NUM_WARPS  per-warp flush (branch/redirect).
- req  out  NUM_WARPS  request vector to the arbiter, combinational.
- grt  in  NUM_WARPS  one-hot grant from the arbiter, same cycle as req.
- issue_valid  out  1  registered issue strobe.
- issue_warp_id  out  WID_W  warp of the issued instruction.
- issue_instr  out  INSTR_W  issued instruction.
- overflow_err  out  1  sticky: a write was attempted to a full warp.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - All FIFO counts and pointers go to 0.
  - ibuf_full = 0, issue_valid = 0, issue_warp_id = 0, issue_instr = 0, overflow_err = 0.
  - req therefore reads 0 the cycle after reset.
  - Reset asserted mid-operation discards all buffered instructions, and any issue registered on that edge is dropped.
- Request:
  - req[w] = (count[w] != 0) & warp_ready[w] & ~exec_stall & ~flush[w].
  - No dependence on grt, so there is no combinational loop.
- Grant:
  - eff_grt = grt & req; grant bits outside req are ignored.
  - If eff_grt is nonzero, at the next clk edge pop that warp's head and set issue_valid = 1, issue_warp_id = index of eff_grt, issue_instr = head.
  - Otherwise issue_valid = 0 and issue_warp_id/issue_instr hold their previous values.
  - Latency: grant cycle to issue_valid is 1 cycle.
- Write:
  - On fetch_valid with count[fetch_warp_id] < DEPTH, push at the tail.
  - On fetch_valid to a full warp: the write is dropped and overflow_err is set (sticky until rst). This applies even if the same warp is popped that cycle, because ibuf_full is registered.
- Same-cycle push and pop to the same warp (count neither 0 nor DEPTH): count is unchanged, and both pointers advance modulo DEPTH.
- Pointers wrap modulo DEPTH. Count has width clog2(DEPTH)+1.
- ibuf_full[w] is registered and equals (next count[w] == DEPTH).
- Flush:
  - flush[w] at an edge clears count[w] and both pointers of warp w.
  - Flush wins over a same-cycle write or pop to w; the write is dropped without setting overflow_err, and no issue occurs.
  - Other warps are unaffected.
- exec_stall = 1 forces req = 0; no pops occur and FIFO contents hold.
- An empty warp never requests, even when warp_ready is 1.

Decomposition:
- Shared package/header holds NUM_WARPS, WID_W, INSTR_W, the clog2 function, and a one-hot-to-index function (also used by scheduler logging).
- One natural sub-module: ibuf_warp_fifo (DEPTH x INSTR_W, ports push/pop/flush/head/count/full), instantiated NUM_WARPS times via generate.
- Request masking, grant decode and the issue register stay in the top module.

Test Plan:
- Write 0xA0000001 then 0xA0000002 to warp 3, warp_ready = 0xFF, grt = 0x08 for two cycles -> issue_valid pulses twice with warp_id 3 and instr 0xA0000001 then 0xA0000002, and ibuf_full[3] goes 1 then 0.
- Fill warp 5 (2 writes), then write a third word -> ibuf_full[5] = 1, the third word is not stored, and overflow_err = 1 until rst.
- Warp 2 holds 1 entry, warp_ready[2] = 0 -> req[2] = 0. Set warp_ready[2] = 1 -> req[2] = 1, and with grt = 0x04 the next cycle gives issue_warp_id = 2.
- Warp 1 holds 2 entries; assert flush[1] together with grt = 0x02 and a fetch write to warp 1 -> no issue, count[1] = 0, req[1] = 0, overflow_err = 0.
- exec_stall = 1 with warps 0 and 4 non-empty -> req = 0x00 and issue_valid stays 0. Deassert exec_stall -> req = 0x11.
- Warp 6 holds 1 entry; push and grant warp 6 in the same cycle -> issue of the old head, count[6] stays 1, and the new word issues on the next grant. Then apply rst mid-stream -> all outputs 0 and req = 0.
